// File: rtl/bit_diff_arbiter.sv
// Round-robin sequencer sharing one bit_diff unit among NUM_REQ requesters.
// One job in flight: grant, launch, wait for done, then a one-cycle ack.
module bit_diff_arbiter #(
   parameter  int NUM_REQ = 4,
   parameter  int WIDTH   = 8,
   localparam int RW      = $clog2(2*WIDTH+1),
   localparam int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]       ack,
   output logic signed [RW-1:0]     resp_result,
   output logic [IW-1:0]            resp_id,
   output logic                     busy,
   output logic                     unit_go,
   output logic [WIDTH-1:0]         unit_data,
   input  logic signed [RW-1:0]     unit_result,
   input  logic                     unit_done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_RESPOND
   } state_t;

   localparam logic [IW:0]        NQ   = (IW+1)'(NUM_REQ);
   localparam logic [IW-1:0]      LAST = IW'(NUM_REQ-1);
   localparam logic [NUM_REQ-1:0] ONE  = NUM_REQ'(1);

   state_t          state;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   grant;
   logic [IW-1:0]   pick;
   logic            found;
   logic [IW:0]     sum;
   logic [WIDTH-1:0] pick_data;

   // Scan ptr+1, ptr+2, ... so the last winner has lowest priority.
   always_comb begin
      pick  = ptr;
      found = 1'b0;
      sum   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= NQ) begin
            sum = sum - NQ;
         end
         if (!found && req[sum[IW-1:0]]) begin
            pick  = sum[IW-1:0];
            found = 1'b1;
         end
      end
   end

   always_comb begin
      pick_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pick == IW'(i)) begin
            pick_data = req_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         ack         <= '0;
         resp_result <= '0;
         resp_id     <= '0;
         busy        <= 1'b0;
         unit_go     <= 1'b0;
         unit_data   <= '0;
         ptr         <= LAST;
         grant       <= '0;
      end else begin
         ack     <= '0;
         unit_go <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (found) begin
                  grant     <= pick;
                  unit_data <= pick_data;
                  unit_go   <= 1'b1;
                  busy      <= 1'b1;
                  state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               state <= S_WAIT;
            end
            // done outside WAIT may be a stale level from the previous job
            S_WAIT: begin
               if (unit_done) begin
                  resp_result <= unit_result;
                  resp_id     <= grant;
                  ptr         <= grant;
                  ack         <= ONE << grant;
                  state       <= S_RESPOND;
               end
            end
            S_RESPOND: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_diff_arbiter.sv
// Bench for bit_diff_arbiter: behavioural unit, transaction-level
// round-robin model and directed plus random requester traffic.
module tb_bit_diff_arbiter;

   localparam int N   = 4;
   localparam int W   = 8;
   localparam int RW  = $clog2(2*W+1);
   localparam int IW  = $clog2(N);
   localparam int LAT = W + 3;
   localparam int LIM = 400;

   localparam int OFF  = 0;
   localparam int HOLD = 1;
   localparam int NEWD = 2;
   localparam int RND  = 3;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic [N-1:0]         req = '0;
   logic [N*W-1:0]       req_data = '0;
   logic [N-1:0]         ack;
   logic signed [RW-1:0] resp_result;
   logic [IW-1:0]        resp_id;
   logic                 busy;
   logic                 unit_go;
   logic [W-1:0]         unit_data;
   logic signed [RW-1:0] unit_result = '0;
   logic                 unit_done = 1'b0;

   int checks = 0;
   int failures = 0;

   bit_diff_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .ack(ack), .resp_result(resp_result), .resp_id(resp_id),
      .busy(busy), .unit_go(unit_go), .unit_data(unit_data),
      .unit_result(unit_result), .unit_done(unit_done)
   );

   always #5 clk = ~clk;

   // Unit: done drops after go, rises WIDTH+1 cycles after go, then stays high.
   int         u_cnt = 0;
   bit         u_run = 1'b0;
   logic [W-1:0] u_dat = '0;
   always @(negedge clk) begin
      if (!rst) begin
         u_cnt = 0;
         u_run = 1'b0;
         unit_done = 1'b0;
         unit_result = '0;
      end else if (unit_go) begin
         u_run = 1'b1;
         u_cnt = 0;
         u_dat = unit_data;
      end else if (u_run) begin
         if (u_cnt <= W) u_cnt++;
         unit_done = (u_cnt == W + 1);
         if (unit_done) unit_result = RW'(2 * $countones(u_dat) - W);
      end
   end

   // Reference: one job at a time, grant at cycle g, ack at g+W+3.
   int       cyc = 0;
   int       ptr;
   bit       have_job;
   int       g_idx, g_cyc, g_res;
   int       exp_rr, exp_rid;
   logic [W-1:0] exp_ud;
   logic [N-1:0] exp_ack;

   int       mode [N];
   bit       shot [N];
   logic [W-1:0] dset [N];
   int       last_ack_cyc [N];
   int       last_ack_res [N];
   int       id_log [$];
   int       res_log [$];
   int       a1 [$];

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      have_job = 1'b0;
      ptr = N - 1;
      exp_rr = 0;
      exp_rid = 0;
      exp_ud = '0;
   endtask

   function automatic bit active();
      return have_job && cyc <= g_cyc + LAT;
   endfunction

   task automatic check_cycle();
      exp_ack = '0;
      if (have_job && cyc == g_cyc + LAT) begin
         exp_ack[g_idx] = 1'b1;
         exp_rr = g_res;
         exp_rid = g_idx;
      end
      chk("ack", ack, exp_ack);
      chk("busy", busy, active() && cyc > g_cyc);
      chk("unit_go", unit_go, have_job && cyc == g_cyc + 1);
      chk("unit_data", unit_data, exp_ud);
      chk("resp_result", resp_result, exp_rr);
      chk("resp_id", resp_id, exp_rid);
      for (int i = 0; i < N; i++) begin
         if (ack[i]) begin
            last_ack_cyc[i] = cyc;
            last_ack_res[i] = int'(resp_result);
            id_log.push_back(int'(resp_id));
            res_log.push_back(int'(resp_result));
            if (i == 1) a1.push_back(cyc);
         end
      end
   endtask

   task automatic policy();
      for (int i = 0; i < N; i++) begin
         if (exp_ack[i]) begin
            if (mode[i] == OFF) req[i] = 1'b0;
            else if (mode[i] == NEWD) req_data[i*W +: W] = W'($urandom);
            else if (mode[i] == RND) begin
               if ($urandom_range(1) == 0) req[i] = 1'b0;
               else req_data[i*W +: W] = W'($urandom);
            end
         end else if (!req[i]) begin
            if (shot[i]) begin
               req[i] = 1'b1;
               req_data[i*W +: W] = dset[i];
               shot[i] = 1'b0;
            end else if (mode[i] == HOLD) begin
               req[i] = 1'b1;
               req_data[i*W +: W] = dset[i];
            end else if (mode[i] == NEWD ||
                         (mode[i] == RND && $urandom_range(3) == 0)) begin
               req[i] = 1'b1;
               req_data[i*W +: W] = W'($urandom);
            end
         end
      end
   endtask

   task automatic decide();
      int i;
      if (rst && !active() && req != '0) begin
         for (int k = 1; k <= N; k++) begin
            i = (ptr + k) % N;
            if (req[i]) begin
               have_job = 1'b1;
               g_idx = i;
               g_cyc = cyc;
               exp_ud = req_data[i*W +: W];
               g_res = 2 * $countones(exp_ud) - W;
               ptr = i;
               break;
            end
         end
      end
   endtask

   task automatic tick(input bit rel = 1'b0);
      @(negedge clk);
      cyc++;
      check_cycle();
      if (rel) begin
         #2;
         rst = 1'b1;
      end
      policy();
      decide();
   endtask

   task automatic drain();
      int n;
      for (int i = 0; i < N; i++) begin
         mode[i] = OFF;
         shot[i] = 1'b0;
      end
      n = 0;
      while (!(req == '0 && !active()) && n < LIM) begin
         tick();
         n++;
      end
      chk("drain_bound", n < LIM, 1);
      tick();
   endtask

   int exp3_id  [5] = '{0, 1, 2, 3, 0};
   int exp3_res [5] = '{-8, 0, 0, 0, -8};
   int exp4_id  [4] = '{0, 2, 0, 2};

   initial begin
      int n;
      int c;
      for (int i = 0; i < N; i++) begin
         mode[i] = OFF;
         shot[i] = 1'b0;
         dset[i] = '0;
         last_ack_cyc[i] = 0;
         last_ack_res[i] = 0;
      end
      model_reset();
      #2 rst = 1'b0;
      repeat (3) tick();
      tick(1'b1);

      // single request, data all ones
      dset[0] = 8'hFF;
      shot[0] = 1'b1;
      tick();
      c = g_cyc;
      drain();
      chk("t2_latency", last_ack_cyc[0] - c, 11);
      chk("t2_result", last_ack_res[0], 8);

      // reset in the middle of WAIT abandons the job
      dset[0] = 8'h00;
      dset[1] = 8'h0F;
      dset[2] = 8'hF0;
      dset[3] = 8'h55;
      shot[2] = 1'b1;
      n = 0;
      while (!(have_job && g_idx == 2 && cyc == g_cyc + 4) && n < LIM) begin
         tick();
         n++;
      end
      chk("t1_reach_wait", n < LIM, 1);
      @(negedge clk);
      cyc++;
      check_cycle();
      #2 rst = 1'b0;
      #1;
      chk("t1_ack", ack, 0);
      chk("t1_busy", busy, 0);
      chk("t1_go", unit_go, 0);
      chk("t1_data", unit_data, 0);
      chk("t1_result", resp_result, 0);
      chk("t1_id", resp_id, 0);
      model_reset();
      for (int i = 0; i < N; i++) mode[i] = HOLD;
      repeat (2) tick();
      id_log.delete();
      res_log.delete();
      tick(1'b1);

      // all requesting: pointer restarts so order begins at 0
      n = 0;
      while (id_log.size() < 5 && n < LIM) begin
         tick();
         n++;
      end
      chk("t3_acks", id_log.size() >= 5, 1);
      for (int i = 0; i < 5 && i < id_log.size(); i++) begin
         chk($sformatf("t3_id%0d", i), id_log[i], exp3_id[i]);
         chk($sformatf("t3_res%0d", i), res_log[i], exp3_res[i]);
      end
      drain();

      // req2 joins while req0 is in WAIT
      mode[0] = NEWD;
      n = 0;
      while (!(have_job && g_idx == 0 && cyc >= g_cyc + 2 &&
               cyc <= g_cyc + W) && n < LIM) begin
         tick();
         n++;
      end
      chk("t4_reach_wait", n < LIM, 1);
      id_log.delete();
      mode[2] = NEWD;
      n = 0;
      while (id_log.size() < 4 && n < LIM) begin
         tick();
         n++;
      end
      chk("t4_acks", id_log.size() >= 4, 1);
      for (int i = 0; i < 4 && i < id_log.size(); i++)
         chk($sformatf("t4_id%0d", i), id_log[i], exp4_id[i]);
      drain();

      // idle with the unit's done still high from the last job
      repeat (10) tick();
      dset[3] = 8'h07;
      shot[3] = 1'b1;
      tick();
      c = g_cyc;
      drain();
      chk("t5_latency", last_ack_cyc[3] - c, LAT);
      chk("t5_result", last_ack_res[3], -2);

      // back-to-back jobs from one requester with fresh data
      a1.delete();
      mode[1] = NEWD;
      n = 0;
      while (a1.size() < 3 && n < LIM) begin
         tick();
         n++;
      end
      chk("t6_acks", a1.size() >= 3, 1);
      if (a1.size() >= 3) begin
         chk("t6_space0", a1[1] - a1[0], W + 4);
         chk("t6_space1", a1[2] - a1[1], W + 4);
      end
      drain();

      // random traffic
      for (int i = 0; i < N; i++) mode[i] = RND;
      repeat (3000) tick();
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
